// File: rtl/alu_pkg.sv
// Shared constants for the ALU datapath: widths, aluOp codes and flag bit positions.
package alu_pkg;

   localparam int DW   = 16;
   localparam int NREG = 16;
   localparam int IDXW = $clog2(NREG);

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t ALU_ADD   = 4'd0;
   localparam alu_op_t ALU_SUB   = 4'd1;
   localparam alu_op_t ALU_AND   = 4'd2;
   localparam alu_op_t ALU_OR    = 4'd3;
   localparam alu_op_t ALU_XOR   = 4'd4;
   localparam alu_op_t ALU_NOT   = 4'd5;
   localparam alu_op_t ALU_SHL1  = 4'd6;
   localparam alu_op_t ALU_SHR1  = 4'd7;
   localparam alu_op_t ALU_PASSB = 4'd8;

   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_NEG   = 2;
   localparam int NFLAGS     = 3;

   // True when at least two of the three bus drivers are active.
   function automatic logic multi_driver(input logic d0, input logic d1, input logic d2);
      return (d0 & d1) | (d0 & d2) | (d1 & d2);
   endfunction

endpackage

// File: rtl/alu_datapath_if.sv
// Control-strobe and observation bundle between the control FSMs and the datapath.
interface alu_datapath_if;
   import alu_pkg::*;

   logic [IDXW-1:0] rxOut;
   logic [IDXW-1:0] rxIn;
   logic            ALUin0;
   logic            ALUin1;
   logic            ALUoutlatch;
   logic            ALUoutEN;
   logic            ALUImmOut;
   logic [DW-1:0]   param2Out;
   logic            pcInc;
   alu_op_t         aluOp;
   logic [DW-1:0]   pc;
   logic [DW-1:0]   bus;
   logic            zero;
   logic            carry;
   logic            neg;
   logic            busConflict;
   logic [IDXW-1:0] dbgSel;
   logic [DW-1:0]   dbgData;

   modport master (
      output rxOut, rxIn, ALUin0, ALUin1, ALUoutlatch, ALUoutEN, ALUImmOut,
             param2Out, pcInc, aluOp, dbgSel,
      input  pc, bus, zero, carry, neg, busConflict, dbgData
   );

   modport slave (
      input  rxOut, rxIn, ALUin0, ALUin1, ALUoutlatch, ALUoutEN, ALUImmOut,
             param2Out, pcInc, aluOp, dbgSel,
      output pc, bus, zero, carry, neg, busConflict, dbgData
   );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: operands and op code in, truncated result and carry/borrow out.
module alu_core #(
   parameter int DW = 16
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [3:0]    op,
   output logic [DW-1:0] result,
   output logic          carry
);
   import alu_pkg::*;

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         ALU_ADD:   {carry, result} = {1'b0, a} + {1'b0, b};
         ALU_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         ALU_AND:   result = a & b;
         ALU_OR:    result = a | b;
         ALU_XOR:   result = a ^ b;
         ALU_NOT:   result = ~a;
         ALU_SHL1: begin
            result = {a[DW-2:0], 1'b0};
            carry  = a[DW-1];
         end
         ALU_SHR1: begin
            result = {1'b0, a[DW-1:1]};
            carry  = a[0];
         end
         ALU_PASSB: result = b;
         default:   result = a;
      endcase
   end

endmodule

// File: rtl/alu_datapath.sv
// Register file, operand/result latches, bus mux, PC and sticky bus-conflict tracking,
// all driven purely by control strobes from the instruction FSMs.
module alu_datapath #(
   parameter int DW   = 16,
   parameter int NREG = 16
) (
   input  logic           clk,
   input  logic           rst,
   alu_datapath_if.slave  dp
);
   import alu_pkg::*;

   logic [DW-1:0]     rf [NREG];
   logic [DW-1:0]     opa;
   logic [DW-1:0]     opb;
   logic [DW-1:0]     outr;
   logic [DW-1:0]     pc_q;
   logic [DW-1:0]     bus_v;
   logic [DW-1:0]     alu_res;
   logic              alu_carry;
   logic [NFLAGS-1:0] flags;
   logic              conflict;
   logic              multi_drv;

   // Fixed-priority bus resolution; rf[0] is never written so it always reads 0.
   always_comb begin
      bus_v = '0;
      if (dp.ALUoutEN)
         bus_v = outr;
      else if (dp.ALUImmOut)
         bus_v = dp.param2Out;
      else if (dp.rxOut != '0)
         bus_v = rf[dp.rxOut];
   end

   assign multi_drv = multi_driver(dp.ALUoutEN, dp.ALUImmOut, (dp.rxOut != '0));

   alu_core #(.DW(DW)) u_core (
      .a      (opa),
      .b      (opb),
      .op     (dp.aluOp),
      .result (alu_res),
      .carry  (alu_carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
         opa      <= '0;
         opb      <= '0;
         outr     <= '0;
         pc_q     <= '0;
         flags    <= '0;
         conflict <= 1'b0;
      end else begin
         if (dp.rxIn != '0) rf[dp.rxIn] <= bus_v;
         if (dp.ALUin0) opa <= bus_v;
         if (dp.ALUin1) opb <= bus_v;
         // The ALU sees pre-edge operands, so a same-cycle operand load does not affect OUT.
         if (dp.ALUoutlatch) begin
            outr              <= alu_res;
            flags[FLAG_ZERO]  <= (alu_res == '0);
            flags[FLAG_CARRY] <= alu_carry;
            flags[FLAG_NEG]   <= alu_res[DW-1];
         end
         if (dp.pcInc) pc_q <= pc_q + 1'b1;
         if (multi_drv) conflict <= 1'b1;
      end
   end

   assign dp.bus         = bus_v;
   assign dp.pc          = pc_q;
   assign dp.zero        = flags[FLAG_ZERO];
   assign dp.carry       = flags[FLAG_CARRY];
   assign dp.neg         = flags[FLAG_NEG];
   assign dp.busConflict = conflict;
   assign dp.dbgData     = rf[dp.dbgSel];

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath: ALU op table plus hand-written strobe sequences.
module tb_alu_datapath;
   import alu_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   alu_datapath_if dp ();

   alu_datapath dut (
      .clk (clk),
      .rst (rst),
      .dp  (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  op;
      logic [15:0] res;
      logic        c;
      logic        z;
      logic        n;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle();
      dp.rxOut       = '0;
      dp.rxIn        = '0;
      dp.ALUin0      = 1'b0;
      dp.ALUin1      = 1'b0;
      dp.ALUoutlatch = 1'b0;
      dp.ALUoutEN    = 1'b0;
      dp.ALUImmOut   = 1'b0;
      dp.param2Out   = '0;
      dp.pcInc       = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reg(input int idx, input logic [15:0] exp);
      dp.dbgSel = idx[3:0];
      #1;
      chk($sformatf("R%0d", idx), dp.dbgData, exp);
   endtask

   // Load A, load B, latch OUT, then read OUT back over the bus and check flags.
   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input logic [15:0] res,
                         input logic c, input logic z, input logic n);
      idle();
      dp.aluOp     = op;
      dp.ALUImmOut = 1'b1;
      dp.param2Out = a;
      dp.ALUin0    = 1'b1;
      tick();
      idle();
      dp.ALUImmOut = 1'b1;
      dp.param2Out = b;
      dp.ALUin1    = 1'b1;
      tick();
      idle();
      dp.ALUoutlatch = 1'b1;
      tick();
      idle();
      dp.ALUoutEN = 1'b1;
      #1;
      chk({name, "_out"}, dp.bus, res);
      chk({name, "_carry"}, dp.carry, c);
      chk({name, "_zero"}, dp.zero, z);
      chk({name, "_neg"}, dp.neg, n);
      idle();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      total = 0;
      bad   = 0;
      vecs[0]  = '{16'h0003, 16'h0004, ALU_ADD,   16'h0007, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{16'hFFFF, 16'h0001, ALU_ADD,   16'h0000, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{16'h0003, 16'h0005, ALU_SUB,   16'hFFFE, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{16'h0007, 16'h0007, ALU_SUB,   16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{16'hF0F0, 16'h3C3C, ALU_AND,   16'h3030, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{16'hF0F0, 16'h0F00, ALU_OR,    16'hFFF0, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{16'hAAAA, 16'hFFFF, ALU_XOR,   16'h5555, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{16'h00FF, 16'h1234, ALU_NOT,   16'hFF00, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{16'h8001, 16'h0000, ALU_SHL1,  16'h0002, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{16'h0003, 16'h0000, ALU_SHR1,  16'h0001, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{16'h1111, 16'h8000, ALU_PASSB, 16'h8000, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{16'h4321, 16'h0000, 4'd12,     16'h4321, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{16'h0000, 16'hFFFF, ALU_AND,   16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{16'h8000, 16'h8000, ALU_ADD,   16'h0000, 1'b1, 1'b1, 1'b0};

      rst       = 1'b1;
      dp.aluOp  = ALU_ADD;
      dp.dbgSel = '0;
      idle();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pc", dp.pc, 16'h0000);
      chk("rst_bus", dp.bus, 16'h0000);
      chk("rst_flags", {dp.zero, dp.carry, dp.neg}, 3'b000);
      chk("rst_conflict", dp.busConflict, 1'b0);
      chk_reg(1, 16'h0000);
      chk_reg(15, 16'h0000);
      rst = 1'b0;
      tick();

      // Immediate load into R1.
      dp.ALUImmOut = 1'b1;
      dp.param2Out = 16'd5;
      dp.rxIn      = 4'd1;
      #1;
      chk("imm_bus", dp.bus, 16'd5);
      tick();
      idle();
      chk_reg(1, 16'd5);

      // ADD R1, 4 as a four-cycle instruction.
      dp.aluOp  = ALU_ADD;
      dp.rxOut  = 4'd1;
      dp.ALUin0 = 1'b1;
      tick();
      idle();
      dp.ALUImmOut = 1'b1;
      dp.param2Out = 16'd4;
      dp.ALUin1    = 1'b1;
      tick();
      idle();
      dp.ALUoutlatch = 1'b1;
      tick();
      idle();
      dp.ALUoutEN = 1'b1;
      dp.rxIn     = 4'd1;
      dp.pcInc    = 1'b1;
      #1;
      chk("add_bus", dp.bus, 16'd9);
      tick();
      idle();
      chk_reg(1, 16'd9);
      chk("add_pc", dp.pc, 16'd1);
      chk("add_zero", dp.zero, 1'b0);
      chk("add_carry", dp.carry, 1'b0);

      // Self rewrite and register-to-register copy.
      dp.rxOut = 4'd1;
      dp.rxIn  = 4'd1;
      tick();
      dp.rxIn = 4'd2;
      tick();
      idle();
      chk_reg(1, 16'd9);
      chk_reg(2, 16'd9);

      // rxIn=0 loads nothing.
      dp.ALUImmOut = 1'b1;
      dp.param2Out = 16'hAAAA;
      tick();
      idle();
      for (int i = 0; i < 16; i++)
         chk_reg(i, (i == 1 || i == 2) ? 16'd9 : 16'd0);

      // Operand load and result latch in the same cycle.
      run_op("pre_sim", 16'd2, 16'd3, ALU_ADD, 16'd5, 1'b0, 1'b0, 1'b0);
      dp.ALUImmOut   = 1'b1;
      dp.param2Out   = 16'd100;
      dp.ALUin0      = 1'b1;
      dp.ALUoutlatch = 1'b1;
      tick();
      idle();
      // Latch with ALUoutEN: the bus and R3 see the old OUT.
      dp.ALUoutlatch = 1'b1;
      dp.ALUoutEN    = 1'b1;
      dp.rxIn        = 4'd3;
      #1;
      chk("sim_old_out_bus", dp.bus, 16'd5);
      tick();
      idle();
      chk_reg(3, 16'd5);
      dp.ALUoutEN = 1'b1;
      #1;
      chk("sim_new_out", dp.bus, 16'd103);
      idle();

      // Both operands from one bus value.
      dp.ALUImmOut = 1'b1;
      dp.param2Out = 16'd6;
      dp.ALUin0    = 1'b1;
      dp.ALUin1    = 1'b1;
      tick();
      idle();
      dp.ALUoutlatch = 1'b1;
      tick();
      idle();
      dp.ALUoutEN = 1'b1;
      #1;
      chk("dual_operand", dp.bus, 16'd12);
      idle();

      for (int i = 0; i < 14; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].n);

      // Bus conflict: OUT wins, flag is sticky.
      run_op("pre_conf", 16'h1234, 16'h0001, ALU_ADD, 16'h1235, 1'b0, 1'b0, 1'b0);
      chk("conf_before", dp.busConflict, 1'b0);
      dp.ALUoutEN  = 1'b1;
      dp.ALUImmOut = 1'b1;
      dp.param2Out = 16'hBEEF;
      #1;
      chk("conf_bus", dp.bus, 16'h1235);
      chk("conf_not_yet", dp.busConflict, 1'b0);
      tick();
      idle();
      chk("conf_set", dp.busConflict, 1'b1);
      repeat (10) tick();
      chk("conf_sticky", dp.busConflict, 1'b1);
      dp.ALUImmOut = 1'b1;
      dp.param2Out = 16'h0F0F;
      dp.rxOut     = 4'd1;
      #1;
      chk("prio_imm_over_reg", dp.bus, 16'h0F0F);
      idle();

      // Asynchronous reset mid-instruction with strobes still active.
      chk("pre_rst_pc", dp.pc, 16'd1);
      dp.ALUoutEN = 1'b1;
      dp.pcInc    = 1'b1;
      dp.ALUin0   = 1'b1;
      dp.rxIn     = 4'd1;
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_pc", dp.pc, 16'h0000);
      chk("mid_rst_out", dp.bus, 16'h0000);
      chk("mid_rst_flags", {dp.zero, dp.carry, dp.neg}, 3'b000);
      chk("mid_rst_conflict", dp.busConflict, 1'b0);
      chk_reg(1, 16'd0);
      chk_reg(2, 16'd0);
      chk_reg(3, 16'd0);
      tick();
      chk("rst_hold_pc", dp.pc, 16'h0000);
      idle();
      @(negedge clk);
      rst = 1'b0;
      tick();
      dp.aluOp       = ALU_ADD;
      dp.ALUoutlatch = 1'b1;
      tick();
      idle();
      dp.ALUoutEN = 1'b1;
      #1;
      chk("rst_operands", dp.bus, 16'h0000);
      chk("rst_operands_zero", dp.zero, 1'b1);
      idle();

      // PC wrap.
      dp.pcInc = 1'b1;
      repeat (65535) tick();
      chk("pc_max", dp.pc, 16'hFFFF);
      tick();
      dp.pcInc = 1'b0;
      chk("pc_wrap", dp.pc, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
